// File: rtl/vga_scan_controller_if.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_controller_if
// Brief    : Raster outputs of the VGA scan controller (coordinates, syncs,
//            pixel strobe and frame pacing) grouped for downstream consumers.
// Revision : 1.0 - initial release
// ============================================================================
interface vga_scan_controller_if;
    logic       VGA_CLK;
    logic       pix_tick;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       VGA_HS;
    logic       VGA_VS;
    logic       VGA_BLANK_N;
    logic       VGA_SYNC_N;
    logic       frame_start;
    logic [7:0] frame_count;

    modport master (
        output VGA_CLK, pix_tick, DrawX, DrawY, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, frame_start, frame_count
    );

    modport slave (
        input  VGA_CLK, pix_tick, DrawX, DrawY, VGA_HS, VGA_VS,
               VGA_BLANK_N, VGA_SYNC_N, frame_start, frame_count
    );
endinterface
`default_nettype wire

// File: rtl/vga_scan_controller.sv
`default_nettype none
// ============================================================================
// Module   : vga_scan_controller
// Brief    : VGA raster generator: pixel-rate divider, h/v counters, syncs,
//            blanking with optional pixel-tick delay, and frame pacing pulse.
// Revision : 1.0 - initial release
// ============================================================================
module vga_scan_controller #(
    parameter int CLK_DIV    = 2,
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 0
) (
    input wire Clk,
    input wire Reset,
    vga_scan_controller_if.master vga
);
    localparam int c_H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int c_DIV_W   = $clog2(CLK_DIV);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(CLK_DIV / 2);
    localparam logic [9:0] c_H_LAST   = 10'(c_H_TOTAL - 1);
    localparam logic [9:0] c_V_LAST   = 10'(c_V_TOTAL - 1);
    localparam logic [9:0] c_H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] c_V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] c_HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] c_HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] c_VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] c_VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    // {hs_n, vs_n, blank_n} idle value: syncs inactive, display blanked
    localparam logic [2:0] c_SYNC_IDLE = 3'b110;

    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_DIV_W-1:0] w_div_next;
    logic               r_pix_tick;
    logic               r_vga_clk;
    logic [9:0]         r_h;
    logic [9:0]         r_v;
    logic [9:0]         w_h_next;
    logic [9:0]         w_v_next;
    logic [2:0]         w_dec_next;
    logic [2:0]         r_dec;
    logic [2:0]         w_sync_out;
    logic               w_frame_edge;
    logic               r_frame_start;
    logic [7:0]         r_frame_count;

    assign w_div_next = (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + c_DIV_W'(1);

    always_comb begin
        w_h_next = r_h;
        w_v_next = r_v;
        if (r_pix_tick) begin
            if (r_h == c_H_LAST) begin
                w_h_next = 10'd0;
                w_v_next = (r_v == c_V_LAST) ? 10'd0 : r_v + 10'd1;
            end else begin
                w_h_next = r_h + 10'd1;
            end
        end
    end

    // Decode the coordinates about to be loaded so the registered syncs line up with DrawX/DrawY
    assign w_dec_next[2] = !((w_h_next >= c_HS_START) && (w_h_next < c_HS_END));
    assign w_dec_next[1] = !((w_v_next >= c_VS_START) && (w_v_next < c_VS_END));
    assign w_dec_next[0] = (w_h_next < c_H_VIS) && (w_v_next < c_V_VIS);

    assign w_frame_edge = r_pix_tick && (r_h == c_H_LAST) && (w_v_next == c_V_VIS);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_div_cnt     <= '0;
            r_pix_tick    <= 1'b0;
            r_vga_clk     <= 1'b0;
            r_h           <= 10'd0;
            r_v           <= 10'd0;
            r_dec         <= c_SYNC_IDLE;
            r_frame_start <= 1'b0;
            r_frame_count <= 8'd0;
        end else begin
            r_div_cnt     <= w_div_next;
            r_pix_tick    <= (w_div_next == c_DIV_LAST);
            r_vga_clk     <= (w_div_next >= c_DIV_HALF);
            r_h           <= w_h_next;
            r_v           <= w_v_next;
            r_dec         <= w_dec_next;
            r_frame_start <= w_frame_edge;
            if (w_frame_edge) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign w_sync_out = r_dec;
        end else begin : g_delay
            logic [2:0] r_stage [SYNC_DELAY];

            // Stage 0 samples the decode of the pixel just finished, giving one tick per stage
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int i = 0; i < SYNC_DELAY; i++) begin
                        r_stage[i] <= c_SYNC_IDLE;
                    end
                end else if (r_pix_tick) begin
                    r_stage[0] <= r_dec;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign w_sync_out = r_stage[SYNC_DELAY-1];
        end
    endgenerate

    assign vga.VGA_CLK     = r_vga_clk;
    assign vga.pix_tick    = r_pix_tick;
    assign vga.DrawX       = r_h;
    assign vga.DrawY       = r_v;
    assign vga.VGA_HS      = w_sync_out[2];
    assign vga.VGA_VS      = w_sync_out[1];
    assign vga.VGA_BLANK_N = w_sync_out[0];
    assign vga.VGA_SYNC_N  = 1'b0;
    assign vga.frame_start = r_frame_start;
    assign vga.frame_count = r_frame_count;
endmodule
`default_nettype wire
